secure_rx_decoder: RTL

SECURE_RX_DECODER -- requirements
Module: secure_rx_decoder

---
 rtl/secure_rx_decoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/secure_rx_decoder.sv
// secure_rx_decoder: four serial Hamming(7,4) receivers with single-bit correction,
// per-channel holding registers and a round-robin arbitrated output register.
module secure_rx_decoder #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in0,
    input  logic       data_in1,
    input  logic       data_in2,
    input  logic       data_in3,
    input  logic       strobe_in0,
    input  logic       strobe_in1,
    input  logic       strobe_in2,
    input  logic       strobe_in3,
    input  logic       out_ready,
    output logic [5:0] data_out,
    output logic       out_valid,
    output logic       corrected_out,
    output logic [7:0] corr_count,
    output logic       overflow,
    output logic       timeout
);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    logic [3:0]    w_din, w_stb, w_done, w_tmo, w_grant, w_corr;
    logic [6:0]    w_word [4];
    logic [2:0]    w_syn  [4];
    logic [3:0]    w_nib  [4];
    logic          w_empty, w_found;
    logic [1:0]    w_gidx;
    // the 7th bit is consumed straight from the input, so only six bits are stored
    logic [5:0]    r_sh   [4];
    logic [2:0]    r_cnt  [4];
    logic [IW-1:0] r_idle [4];
    logic [3:0]    r_hold [4];
    logic [3:0]    r_pend, r_hcorr;
    logic [1:0]    r_ptr;

    assign w_din   = {data_in3, data_in2, data_in1, data_in0};
    assign w_stb   = {strobe_in3, strobe_in2, strobe_in1, strobe_in0};
    assign w_empty = !out_valid || out_ready;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_word[c] = {r_sh[c], w_din[c]};
            w_syn[c]  = {w_word[c][3] ^ w_word[c][2] ^ w_word[c][1] ^ w_word[c][0],
                         w_word[c][5] ^ w_word[c][4] ^ w_word[c][1] ^ w_word[c][0],
                         w_word[c][6] ^ w_word[c][4] ^ w_word[c][2] ^ w_word[c][0]};
            w_nib[c]  = {w_word[c][4] ^ (w_syn[c] == 3'd3), w_word[c][2] ^ (w_syn[c] == 3'd5),
                         w_word[c][1] ^ (w_syn[c] == 3'd6), w_word[c][0] ^ (w_syn[c] == 3'd7)};
            w_corr[c] = |w_syn[c];
            w_done[c] = w_stb[c] && r_cnt[c] == 3'd6;
            w_tmo[c]  = !w_stb[c] && r_cnt[c] != 3'd0 && r_idle[c] == IW'(TIMEOUT_CYC - 1);
        end
    end

    // search starts at r_ptr, which always points one past the last grant
    always_comb begin
        w_found = 1'b0;
        w_gidx  = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!w_found && r_pend[2'(r_ptr + 2'(i))]) begin
                w_found = 1'b1;
                w_gidx  = 2'(r_ptr + 2'(i));
            end
        w_grant = (w_found && w_empty) ? 4'b0001 << w_gidx : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                r_sh[c]   <= '0;
                r_cnt[c]  <= '0;
                r_idle[c] <= '0;
                r_hold[c] <= '0;
            end
            r_pend        <= '0;
            r_hcorr       <= '0;
            r_ptr         <= '0;
            data_out      <= '0;
            out_valid     <= 1'b0;
            corrected_out <= 1'b0;
            corr_count    <= '0;
            overflow      <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (w_stb[c]) begin
                    r_idle[c] <= '0;
                    r_sh[c]   <= w_done[c] ? 6'd0 : w_word[c][5:0];
                    r_cnt[c]  <= w_done[c] ? 3'd0 : r_cnt[c] + 3'd1;
                end else if (w_tmo[c]) begin
                    r_idle[c] <= '0;
                    r_sh[c]   <= '0;
                    r_cnt[c]  <= '0;
                end else
                    r_idle[c] <= (r_cnt[c] != 3'd0) ? r_idle[c] + 1'b1 : '0;
                // a grant on this edge frees the slot for a codeword completing now
                if (w_done[c] && (!r_pend[c] || w_grant[c])) begin
                    r_hold[c]  <= w_nib[c];
                    r_hcorr[c] <= w_corr[c];
                    r_pend[c]  <= 1'b1;
                end else if (w_grant[c])
                    r_pend[c] <= 1'b0;
            end
            overflow <= overflow | |(w_done & r_pend & ~w_grant);
            timeout  <= timeout | |w_tmo;
            if (out_valid && out_ready && corrected_out && corr_count != 8'hFF)
                corr_count <= corr_count + 8'd1;
            if (w_empty) begin
                out_valid <= w_found;
                if (w_found) begin
                    data_out      <= {w_gidx, r_hold[w_gidx]};
                    corrected_out <= r_hcorr[w_gidx];
                    r_ptr         <= 2'(w_gidx + 2'd1);
                end
            end
        end
    end
endmodule
